// File: rtl/accum_window_sampler.sv
// accum_window_sampler: snapshots a saturating accumulator every WINDOW inputs into a 2-entry valid/ready FIFO
// Optional feature macro: ACCUM_SAMPLER_DELTA_EN (per-entry delta to the previous snapshot).
// Ports:
//   clk, rst_b       clock (rising edge), asynchronous active-low reset
//   din_en           accumulator input-enable strobe
//   acc[15:0]        accumulator running total (signed), updates 1 cycle after din_en
//   out_ready        consumer ready
//   ovr_clr          synchronous clear of overrun
//   out_valid        FIFO head valid
//   out_data[15:0]   head snapshot (signed)
//   out_sat          head snapshot sits on a saturation bound
//   out_delta[16:0]  head snapshot minus previous snapshot (0 when feature disabled)
//   overrun          sticky drop flag
module accum_window_sampler #(
    parameter int unsigned        WINDOW    = 16,
    parameter logic signed [15:0] MAX_BOUND = 16'sh7fff,
    parameter logic signed [15:0] MIN_BOUND = -16'sh7fff
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               din_en,
    input  logic signed [15:0] acc,
    input  logic               out_ready,
    input  logic               ovr_clr,
    output logic               out_valid,
    output logic signed [15:0] out_data,
    output logic               out_sat,
    output logic signed [16:0] out_delta,
    output logic               overrun
);
`ifdef ACCUM_SAMPLER_DELTA_EN
    localparam int EW = 34;
`else
    localparam int EW = 17;
`endif
    localparam logic [15:0] LAST = 16'(WINDOW - 1);
    logic [15:0]   cnt_q, cnt_d;
    logic          cap_pend_q, cap_pend_d;
    logic [1:0]    fcnt_q, fcnt_d;
    logic [EW-1:0] mem0_q, mem0_d, mem1_q, mem1_d, entry;
    logic          overrun_q, overrun_d;
    logic          pop, push, sat, wr_slot;
`ifdef ACCUM_SAMPLER_DELTA_EN
    logic signed [15:0] prev_q, prev_d;
    logic [16:0]        delta;
`endif
    always_comb begin
        sat        = acc == MAX_BOUND || acc == MIN_BOUND;
`ifdef ACCUM_SAMPLER_DELTA_EN
        delta      = {acc[15], acc} - {prev_q[15], prev_q};
        entry      = {delta, sat, acc};
        // prev follows every capture, including ones the full FIFO drops
        prev_d     = cap_pend_q ? acc : prev_q;
`else
        entry      = {sat, acc};
`endif
        pop        = out_valid && out_ready;
        // a full FIFO still accepts the capture when the head leaves this cycle
        push       = cap_pend_q && (fcnt_q != 2'd2 || pop);
        overrun_d  = (cap_pend_q && !push) || (overrun_q && !ovr_clr);
        cap_pend_d = din_en && cnt_q == LAST;
        cnt_d      = din_en ? (cnt_q == LAST ? 16'd0 : cnt_q + 16'd1) : cnt_q;
        fcnt_d     = fcnt_q + {1'b0, push} - {1'b0, pop};
        // slot the new entry lands in after any pop has shifted the queue
        wr_slot    = fcnt_q == 2'd2 || (fcnt_q == 2'd1 && !pop);
        mem0_d     = push && !wr_slot ? entry : (pop && fcnt_q == 2'd2 ? mem1_q : mem0_q);
        mem1_d     = push && wr_slot ? entry : mem1_q;
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q      <= '0;
            cap_pend_q <= 1'b0;
            fcnt_q     <= '0;
            mem0_q     <= '0;
            mem1_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cap_pend_q <= cap_pend_d;
            fcnt_q     <= fcnt_d;
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
            overrun_q  <= overrun_d;
        end
    end
`ifdef ACCUM_SAMPLER_DELTA_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) prev_q <= '0;
        else        prev_q <= prev_d;
    end
    assign out_delta = mem0_q[33:17];
`else
    assign out_delta = '0;
`endif
    assign out_valid = fcnt_q != 2'd0;
    assign out_data  = mem0_q[15:0];
    assign out_sat   = mem0_q[16];
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_accum_window_sampler.sv
// tb_accum_window_sampler: scoreboard bench for accum_window_sampler (WINDOW=4 and WINDOW=1 instances)
module tb_accum_window_sampler;
`ifdef ACCUM_SAMPLER_DELTA_EN
    localparam bit DELTA_ON = 1'b1;
`else
    localparam bit DELTA_ON = 1'b0;
`endif
    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic [16:0] dl;
    } ent_t;

    logic clk = 1'b0, rst_b = 1'b0;
    logic din_en = 1'b0, out_ready = 1'b0, ovr_clr = 1'b0;
    logic signed [15:0] acc = '0;
    logic out_valid, out_sat, overrun;
    logic signed [15:0] out_data;
    logic signed [16:0] out_delta;
    logic din_en1 = 1'b0, out_ready1 = 1'b1, ovr_clr1 = 1'b0;
    logic signed [15:0] acc1 = '0;
    logic out_valid1, out_sat1, overrun1;
    logic signed [15:0] out_data1;
    logic signed [16:0] out_delta1;

    int checks = 0, errors = 0;
    ent_t q0[$], q1[$];
    int m_cnt = 0;
    logic m_pend = 1'b0, m_ovr = 1'b0, p1 = 1'b0;
    logic signed [15:0] m_prev = '0, prev1 = '0;

    always #5 clk = ~clk;

    accum_window_sampler #(.WINDOW(4)) dut (
        .clk(clk), .rst_b(rst_b), .din_en(din_en), .acc(acc), .out_ready(out_ready),
        .ovr_clr(ovr_clr), .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
        .out_delta(out_delta), .overrun(overrun));

    accum_window_sampler #(.WINDOW(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .din_en(din_en1), .acc(acc1), .out_ready(out_ready1),
        .ovr_clr(ovr_clr1), .out_valid(out_valid1), .out_data(out_data1), .out_sat(out_sat1),
        .out_delta(out_delta1), .overrun(overrun1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic signed [15:0] a, input logic signed [15:0] p);
        ent_t e;
        e.d  = a;
        e.s  = (a == 16'sh7fff) || (a == -16'sh7fff);
        e.dl = DELTA_ON ? ({a[15], a} - {p[15], p}) : 17'd0;
        return e;
    endfunction

    task automatic tick();
        logic drop;
        @(negedge clk);
        if (!rst_b) begin
            q0.delete(); q1.delete();
            m_cnt = 0; m_pend = 1'b0; m_ovr = 1'b0; m_prev = '0; p1 = 1'b0; prev1 = '0;
            chk("rst_data", {16'd0, out_data}, 32'd0);
            chk("rst_sat", {31'd0, out_sat}, 32'd0);
            chk("rst_delta", {15'd0, out_delta}, 32'd0);
        end
        chk("valid", {31'd0, out_valid}, {31'd0, q0.size() != 0});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (q0.size() != 0) begin
            chk("data", {16'd0, out_data}, {16'd0, q0[0].d});
            chk("sat", {31'd0, out_sat}, {31'd0, q0[0].s});
            chk("delta", {15'd0, out_delta}, {15'd0, q0[0].dl});
            if (out_ready) void'(q0.pop_front());
        end
        chk("valid1", {31'd0, out_valid1}, {31'd0, q1.size() != 0});
        chk("overrun1", {31'd0, overrun1}, 32'd0);
        if (q1.size() != 0) begin
            chk("data1", {16'd0, out_data1}, {16'd0, q1[0].d});
            chk("delta1", {15'd0, out_delta1}, {15'd0, q1[0].dl});
            void'(q1.pop_front());
        end
        if (rst_b) begin
            drop = 1'b0;
            if (m_pend) begin
                if (q0.size() < 2) q0.push_back(mk(acc, m_prev));
                else drop = 1'b1;
                m_prev = acc;
            end
            m_ovr  = drop ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
            m_pend = din_en && m_cnt == 3;
            m_cnt  = din_en ? (m_cnt == 3 ? 0 : m_cnt + 1) : m_cnt;
            if (p1) begin
                q1.push_back(mk(acc1, prev1));
                prev1 = acc1;
            end
            p1 = din_en1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din_en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic win(input logic signed [15:0] v);
        acc = v;
        din_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle(1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        rst_b = 1'b1;
        out_ready = 1'b1;
        // accumulator ramp 10,20,30,40 trailing din_en by one cycle
        din_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            acc = acc + 16'sd10;
        end
        idle(1);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data", {16'd0, out_data}, 32'd40);
        chk("t1_sat", {31'd0, out_sat}, 32'd0);
        chk("t1_delta", {15'd0, out_delta}, DELTA_ON ? 32'd40 : 32'd0);
        idle(1);
        win(16'sh7fff);
        chk("t2_sat_max", {31'd0, out_sat}, 32'd1);
        win(-16'sh7fff);
        chk("t2_sat_min", {31'd0, out_sat}, 32'd1);
        chk("t2_data_min", {16'd0, out_data}, 32'h8001);
        win(16'sh7ffe);
        chk("t2_sat_near", {31'd0, out_sat}, 32'd0);
        win(-16'sh8000);
        chk("t2_sat_8000", {31'd0, out_sat}, 32'd0);
        idle(2);
        out_ready = 1'b0;
        win(16'sd100);
        win(16'sd200);
        win(16'sd300);
        chk("t3_ovr", {31'd0, overrun}, 32'd1);
        chk("t3_head", {16'd0, out_data}, 32'd100);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t3_ovr_clr", {31'd0, overrun}, 32'd0);
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        win(16'sd1);
        win(16'sd2);
        acc = 16'sd3;
        din_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        din_en = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_ovr", {31'd0, overrun}, 32'd0);
        chk("t4_head", {16'd0, out_data}, 32'd2);
        tick();
        chk("t4_full_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        idle(3);
        chk("t4_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        win(16'sd55);
        acc = 16'sd66;
        din_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        din_en = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t6_rst_data", {16'd0, out_data}, 32'd0);
        rst_b = 1'b1;
        acc = 16'sd77;
        din_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        idle(2);
        chk("t6_no_beat", {31'd0, out_valid}, 32'd0);
        din_en = 1'b1;
        tick();
        idle(1);
        chk("t6_beat", {31'd0, out_valid}, 32'd1);
        chk("t6_data", {16'd0, out_data}, 32'd77);
        out_ready = 1'b1;
        idle(2);
        for (int i = 0; i < 8; i++) begin
            din_en1 = 1'b1;
            acc1 = 16'(100 + i);
            tick();
            if (i >= 2) begin
                chk("t5_valid", {31'd0, out_valid1}, 32'd1);
                chk("t5_data", {16'd0, out_data1}, 32'(100 + i));
                chk("t5_delta", {15'd0, out_delta1}, DELTA_ON ? 32'd1 : 32'd0);
            end
        end
        din_en1 = 1'b0;
        idle(3);
        chk("t5_drain", {31'd0, out_valid1}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
